lsu_align: RTL and testbench
============================

Name: lsu_align

Overview:
- Load/store alignment unit that sits directly upstream of the word-indexed data memory (dm).
- Accepts one memory request at a time from the core over a valid/ready handshake.
- Formats loads: byte/half lane extraction with sign or zero extension.
- Formats stores: word stores are written directly; sub-word stores are done as read-modify-write, because the memory only writes low-order lanes natively.
- Drives the memory's DMWr/addr/din and consumes its combinational dout.

Parameters:
- ADDR_HI, 8, highest valid byte-address bit. Any set bit in req_addr[31:ADDR_HI+1] is an error.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (IDLE only)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal (error)
- req_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response pulse; core must accept, no back-pressure
- resp_rdata  out  32  formatted load data; 0 on store and error responses
- resp_err  out  1  misaligned, out-of-range or illegal size; qualified by resp_valid
- dm_DMWr  out  2  memory write control: 00 none, 01 word, 10 low byte, 11 low half
- dm_addr  out  7  word index = latched addr[8:2]
- dm_din  out  32  memory write data
- dm_dout  in  32  memory read data, combinational from dm_addr

Behaviour:
- Reset (rstn low, asynchronous):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; dm_DMWr=00; dm_addr=0; dm_din=0.
  - dm_DMWr is decoded from state, so it drops to 00 immediately even mid-WRITE. No partial write may be issued.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE: req_ready=1. On req_valid at edge E0, latch all request fields, then decode:
  - Error if any of: word with addr[1:0]!=0; half with addr[0]=1; size=11; addr[31:ADDR_HI+1]!=0. Go to RESP with err=1, no memory write.
  - Load -> LOAD.
  - Word store -> WRITE.
  - Byte/half store -> RMW_RD.
- LOAD: dm_addr=latched index, DMWr=00. At the next edge:
  - Byte: extract dm_dout[8k+7:8k], k=addr[1:0].
  - Half: extract dm_dout[16h+15:16h], h=addr[1].
  - Extend per req_unsigned, register into resp_rdata, go to RESP.
  - Load latency: resp_valid is high in the 2nd cycle after acceptance.
- RMW_RD: DMWr=00. At the next edge, capture dm_dout with the selected lane replaced by req_wdata[7:0] or [15:0], then go to WRITE.
- WRITE: DMWr=01 for exactly one cycle; dm_din = req_wdata (word store) or the merged word. Next state RESP.
  - Word store: resp_valid at the 2nd cycle after acceptance.
  - Sub-word store: resp_valid at the 3rd cycle after acceptance.
- RESP: resp_valid=1 for one cycle, req_ready=0, then IDLE.
  - resp_valid, resp_err and resp_rdata return to 0 outside RESP.
- Throughput:
  - Minimum 3 cycles per load / word store.
  - 4 cycles per sub-word store.
  - No overlapping requests.
- req_valid while busy is ignored; the core must hold it until accepted.
- dm_DMWr is never nonzero outside WRITE.
- dm_addr holds its last value in IDLE.

Optional Feature:
- Macro: LSU_NATIVE_SUBWORD_EN.
- Defined: a sub-word store at lane offset 0 (byte addr[1:0]=00, or half addr[1]=0) skips RMW_RD. It goes straight to WRITE with DMWr=10 (byte) or 11 (half) and dm_din=req_wdata, giving word-store latency. Stores at nonzero offsets still use RMW.
- Undefined: every sub-word store uses RMW with DMWr=01.

Test Plan:
- Word store: sw addr 0x10, data 0xDEADBEEF -> one WRITE cycle with dm_DMWr=01, dm_addr=4, dm_din=0xDEADBEEF; resp_valid in 2nd cycle, err=0. Then lw 0x10 -> resp_rdata=0xDEADBEEF.
- Byte loads with word[4]=0xDEADBEEF:
  - lb 0x13 -> 0xFFFFFFDE.
  - lbu 0x13 -> 0x000000DE.
  - lh 0x10 -> 0xFFFFBEEF.
  - lhu 0x12 -> 0x0000DEAD.
- Sub-word store: sh 0x12, data 0x1234 over 0xDEADBEEF -> RMW_RD cycle with DMWr=00, then WRITE DMWr=01, din=0x1234BEEF; resp_valid in 3rd cycle. sb 0x11, data 0x55 -> word becomes 0x123455EF.
- Errors:
  - lw 0x11 -> resp_err=1, resp_rdata=0, no write.
  - sw 0x200 -> resp_err=1, dm_DMWr stays 00 throughout.
  - size=11 -> resp_err=1.
- Reset mid-operation: assert rstn=0 mid-cycle during WRITE -> dm_DMWr=00 before the next edge; memory word unchanged; after release req_ready=1 and resp_valid=0.
- With LSU_NATIVE_SUBWORD_EN: sb 0x10, data 0xAA -> single WRITE with DMWr=10, din=0xAA, no RMW_RD cycle; resp_valid in 2nd cycle. sb 0x11 -> still uses RMW.

Source files
------------

// File: rtl/lsu_align.sv
// Load/store alignment unit in front of a word-indexed data memory.
// Optional LSU_NATIVE_SUBWORD_EN: lane-0 sub-word stores use native DMWr=10/11 writes.
module lsu_align #(
    parameter int ADDR_HI = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [1:0]           dm_DMWr,
    output logic [ADDR_HI-2:0]   dm_addr,
    output logic [31:0]          dm_din,
    input  logic [31:0]          dm_dout
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RMW_RD, S_WRITE, S_RESP
    } state_t;

    state_t state, state_nxt;

    logic               we_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic [ADDR_HI:0]   addr_q;
    logic [31:0]        wbuf_q;   // store data, later the merged RMW word
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               native_q;

    logic               req_err;
    logic               native_ok;
    logic               accept;
    logic [31:0]        load_fmt;
    logic [31:0]        merged;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    assign accept = (state == S_IDLE) && req_valid;

    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)                              req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)    req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])               req_err = 1'b1;
        if ((req_addr >> (ADDR_HI + 1)) != 32'd0)           req_err = 1'b1;
    end

`ifdef LSU_NATIVE_SUBWORD_EN
    assign native_ok = req_we &&
                       ((req_size == 2'b00 && req_addr[1:0] == 2'b00) ||
                        (req_size == 2'b01 && !req_addr[1]));
`else
    assign native_ok = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)                               state_nxt = S_RESP;
                    else if (!req_we)                          state_nxt = S_LOAD;
                    else if (req_size == 2'b10 || native_ok)   state_nxt = S_WRITE;
                    else                                       state_nxt = S_RMW_RD;
                end
            end
            S_LOAD:   state_nxt = S_RESP;
            S_RMW_RD: state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Lane extraction for loads and lane replacement for RMW stores
    always_comb begin
        ld_byte  = dm_dout[{addr_q[1:0], 3'b000} +: 8];
        ld_half  = dm_dout[{addr_q[1], 4'b0000} +: 16];
        load_fmt = dm_dout;
        if (size_q == 2'b00)
            load_fmt = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
        else if (size_q == 2'b01)
            load_fmt = {{16{ld_half[15] & ~uns_q}}, ld_half};
        merged = dm_dout;
        if (size_q == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wbuf_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wbuf_q[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            native_q <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                uns_q    <= req_unsigned;
                addr_q   <= req_addr[ADDR_HI:0];
                wbuf_q   <= req_wdata;
                rdata_q  <= '0;
                err_q    <= req_err;
                native_q <= native_ok && !req_err;
            end
            if (state == S_LOAD)   rdata_q <= load_fmt;
            if (state == S_RMW_RD) wbuf_q  <= merged;
        end
    end

    // All outputs decode from state so reset kills a write immediately
    always_comb begin
        dm_DMWr = 2'b00;
        if (state == S_WRITE) begin
            if (native_q) dm_DMWr = (size_q == 2'b00) ? 2'b10 : 2'b11;
            else          dm_DMWr = 2'b01;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) && err_q;
    assign resp_rdata = (state == S_RESP) ? rdata_q : 32'd0;
    assign dm_addr    = addr_q[ADDR_HI:2];
    assign dm_din     = (state == S_WRITE) ? wbuf_q : 32'd0;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_lsu_align.sv
// Random + directed bench for lsu_align against a byte-array memory model.
module tb_lsu_align;
    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  dm_DMWr;
    logic [6:0]  dm_addr;
    logic [31:0] dm_din, dm_dout;

    logic [31:0] mem [128];
    logic [7:0]  rb  [512];
    logic        fill;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu_align dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dm_DMWr(dm_DMWr), .dm_addr(dm_addr),
        .dm_din(dm_din), .dm_dout(dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 128; i++) mem[i] <= $urandom;
        end else begin
            case (dm_DMWr)
                2'b01:   mem[dm_addr]       <= dm_din;
                2'b10:   mem[dm_addr][7:0]  <= dm_din[7:0];
                2'b11:   mem[dm_addr][15:0] <= dm_din[15:0];
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int wa);
        return {rb[wa*4+3], rb[wa*4+2], rb[wa*4+1], rb[wa*4]};
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        logic        e, native;
        int          lat, nb, nw, got_lat;
        logic [31:0] er, ed, val, got_din, got_rdata;
        logic [1:0]  ew, got_w;
        logic [6:0]  got_addr;
        logic        got_err;

        e = (sz == 2'b11) || (sz == 2'b10 && a[1:0] != 2'b00) ||
            (sz == 2'b01 && a[0]) || (a > 32'h1FF);
        native = 1'b0;
`ifdef LSU_NATIVE_SUBWORD_EN
        native = we && !e && ((sz == 2'b00 && a[1:0] == 2'b00) || (sz == 2'b01 && !a[1]));
`endif
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (e)                             lat = 1;
        else if (!we || sz == 2'b10 || native) lat = 2;
        else                               lat = 3;
        er = 0; ed = 0; ew = 0;
        if (!e && !we) begin
            val = 0;
            for (int i = 0; i < nb; i++) val |= 32'(rb[int'(a) + i]) << (8 * i);
            if (!uns && nb == 1 && val[7])  val |= 32'hFFFFFF00;
            if (!uns && nb == 2 && val[15]) val |= 32'hFFFF0000;
            er = val;
        end
        if (!e && we) begin
            for (int i = 0; i < nb; i++) rb[int'(a) + i] = wd[8*i +: 8];
            ed = native ? wd : ref_word(int'(a) / 4);
            ew = native ? ((sz == 2'b00) ? 2'b10 : 2'b11) : 2'b01;
        end

        @(negedge clk);
        chk("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        nw = 0; got_lat = 0; got_err = 0; got_rdata = 0;
        got_din = 0; got_addr = 0; got_w = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (dm_DMWr != 2'b00) begin
                nw++; got_w = dm_DMWr; got_din = dm_din; got_addr = dm_addr;
            end
            if (resp_valid) begin
                got_lat = c; got_err = resp_err; got_rdata = resp_rdata;
                break;
            end
        end
        chk("latency", got_lat, lat);
        chk("err", {31'd0, got_err}, {31'd0, e});
        chk("rdata", got_rdata, er);
        chk("nwrites", nw, (we && !e) ? 1 : 0);
        if (we && !e) begin
            chk("dmwr", {30'd0, got_w}, {30'd0, ew});
            chk("dm_addr", {25'd0, got_addr}, {25'd0, a[8:2]});
            chk("dm_din", got_din, ed);
        end
    endtask

    initial begin
        logic [31:0] old;
        int bad;
        rstn = 1'b0; fill = 1'b1;
        req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(posedge clk);
        fill = 1'b0;
        #1;
        for (int i = 0; i < 512; i++) rb[i] = mem[i/4][8*(i%4) +: 8];
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_err",   {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_dmwr",  {30'd0, dm_DMWr}, 32'd0);
        chk("rst_addr",  {25'd0, dm_addr}, 32'd0);
        chk("rst_din",   dm_din, 32'd0);
        @(negedge clk) rstn = 1'b1;

        // directed scenarios
        do_req(1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
        do_req(0, 2'b10, 0, 32'h10, 0);
        do_req(0, 2'b00, 0, 32'h13, 0);
        do_req(0, 2'b00, 1, 32'h13, 0);
        do_req(0, 2'b01, 0, 32'h10, 0);
        do_req(0, 2'b01, 1, 32'h12, 0);
        do_req(1, 2'b01, 0, 32'h12, 32'h00001234);
        do_req(1, 2'b00, 0, 32'h11, 32'h00000055);
        chk("word4_merged", mem[4], 32'h123455EF);
        do_req(0, 2'b10, 0, 32'h11, 0);
        do_req(1, 2'b10, 0, 32'h200, 32'h11111111);
        do_req(0, 2'b11, 0, 32'h20, 0);
        do_req(1, 2'b00, 0, 32'h10, 32'h000000AA);
        do_req(1, 2'b00, 0, 32'h11, 32'h000000BB);
        do_req(1, 2'b01, 0, 32'h20, 32'hCCCC5678);

        // reset while WRITE is active
        old = mem[16];
        @(negedge clk);
        req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h40;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 0;
        #2 rstn = 1'b0;
        #1 chk("midrst_dmwr", {30'd0, dm_DMWr}, 32'd0);
        @(posedge clk);
        #1 chk("midrst_mem", mem[16], old);
        @(negedge clk) rstn = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_valid", {31'd0, resp_valid}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a = $urandom_range(0, 511);
            if ($urandom_range(0, 15) == 0) a = $urandom | 32'h200;
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) sz = 2'b11;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b10) a[1:0] = 2'b00;
                if (sz == 2'b01) a[0] = 1'b0;
            end
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        bad = 0;
        for (int w = 0; w < 128; w++) if (mem[w] !== ref_word(w)) bad++;
        chk("mem_image", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
